// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: oversampling I2S receiver for the PCM1808 stream.
// Synchronises bck/lrck/sdata into clk_100m and locks on the start of a left slot.
// Deserialises MSB-first DATA_W-bit left/right samples and hands each stereo
// frame out on a valid/ready interface.
// Ports:
//   clk_100m, rst_n       system clock, async active-low reset
//   bck, lrck, sdata      raw I2S inputs (asynchronous to clk_100m)
//   err_clr               pulse, clears overrun/frame_err
//   out_l, out_r          held stereo frame (two's complement)
//   out_valid, out_ready  frame handshake
//   overrun               sticky, a frame was dropped while the output was full
//   frame_err             sticky, an lrck half-period was not SLOT_W bck periods
module i2s_rx_deser #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned SLOT_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              bck,
  input  logic              lrck,
  input  logic              sdata,
  input  logic              err_clr,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned BIT_CNT_W  = $clog2(DATA_W + 2);
  localparam int unsigned SLOT_CNT_W = $clog2(SLOT_W + 2);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LEFT     = 2'd1,
    RIGHT    = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, sdata_sync;
  logic                   bck_d;
  logic                   bck_s, lrck_s, sdata_s, rise, trans;

  state_t                 state, state_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [SLOT_CNT_W-1:0]  slot_cnt, slot_cnt_nxt;
  logic                   lr_prev, lr_prev_nxt;
  logic [DATA_W-1:0]      shift_q, shift_nxt;
  logic [DATA_W-1:0]      left_hold, left_hold_nxt;
  logic                   left_ok, left_ok_nxt;
  logic                   frame_q, frame_nxt;
  logic                   ferr_set;

  // Equal-depth synchronisers; bck_d gives the rising-edge strobe.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      bck_sync   <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bck_d      <= 1'b0;
    end else begin
      bck_sync   <= {bck_sync[SYNC_STAGES-2:0], bck};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], lrck};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
      bck_d      <= bck_s;
    end
  end

  assign bck_s   = bck_sync[SYNC_STAGES-1];
  assign lrck_s  = lrck_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign rise    = bck_s & ~bck_d;
  assign trans   = lrck_s ^ lr_prev;

  // Protocol state register.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      bit_cnt   <= '0;
      slot_cnt  <= '0;
      lr_prev   <= 1'b0;
      shift_q   <= '0;
      left_hold <= '0;
      left_ok   <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      slot_cnt  <= slot_cnt_nxt;
      lr_prev   <= lr_prev_nxt;
      shift_q   <= shift_nxt;
      left_hold <= left_hold_nxt;
      left_ok   <= left_ok_nxt;
      frame_q   <= frame_nxt;
    end
  end

  // Next-state: everything advances only on a bck rise.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    slot_cnt_nxt  = slot_cnt;
    lr_prev_nxt   = lr_prev;
    shift_nxt     = shift_q;
    left_hold_nxt = left_hold;
    left_ok_nxt   = left_ok;
    frame_nxt     = 1'b0;
    ferr_set      = 1'b0;
    if (rise) begin
      lr_prev_nxt = lrck_s;
      case (state)
        UNLOCKED: begin
          // Only a falling lrck marks a clean left-slot start.
          if (trans && !lrck_s) begin
            state_nxt    = LEFT;
            bit_cnt_nxt  = '0;
            slot_cnt_nxt = SLOT_CNT_W'(1);
          end
        end
        LEFT, RIGHT: begin
          if (trans) begin
            // The transition rise carries the previous LSB and opens the new slot.
            if (slot_cnt != SLOT_CNT_W'(SLOT_W)) begin
              ferr_set    = 1'b1;
              left_ok_nxt = 1'b0;
            end
            slot_cnt_nxt = SLOT_CNT_W'(1);
            bit_cnt_nxt  = '0;
            state_nxt    = lrck_s ? RIGHT : LEFT;
          end else begin
            if (slot_cnt != SLOT_CNT_W'(SLOT_W + 1)) slot_cnt_nxt = slot_cnt + SLOT_CNT_W'(1);
            if (bit_cnt != BIT_CNT_W'(DATA_W + 1))   bit_cnt_nxt  = bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt < BIT_CNT_W'(DATA_W)) shift_nxt = {shift_q[DATA_W-2:0], sdata_s};
            if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
              if (state == LEFT) begin
                left_hold_nxt = shift_nxt;
                left_ok_nxt   = 1'b1;
              end else begin
                frame_nxt   = left_ok;
                left_ok_nxt = 1'b0;
              end
            end
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  // Output holding register; the right sample is still in shift_q while frame_q is high.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else if (frame_q) begin
      if (!out_valid || out_ready) begin
        out_l     <= left_hold;
        out_r     <= shift_q;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flags; a set event beats err_clr.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (frame_q && out_valid && !out_ready) overrun <= 1'b1;
      else if (err_clr)                       overrun <= 1'b0;
      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// tb_i2s_rx_deser: directed bench for i2s_rx_deser driving I2S frames from a
// simple bck/lrck/sdata generator (bck period = 8 clk_100m) and checking held frames.
module tb_i2s_rx_deser;

  logic        clk_100m;
  logic        rst_n;
  logic        bck, lrck, sdata, err_clr, out_ready;
  logic [23:0] out_l, out_r;
  logic        out_valid, overrun, frame_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          valid_rise_cyc = 0;
  int          lsb_rise_cyc = 0;
  bit          rdy_pulse = 1'b0;
  logic        prev_lsb = 1'b0;
  logic [23:0] frame_l, frame_r;
  logic [47:0] acc_q[$];

  i2s_rx_deser #(.DATA_W(24), .SLOT_W(32), .SYNC_STAGES(2)) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bck      (bck),
    .lrck     (lrck),
    .sdata    (sdata),
    .err_clr  (err_clr),
    .out_l    (out_l),
    .out_r    (out_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  initial clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;
  always @(posedge clk_100m) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [47:0] exp);
    logic [47:0] got;
    if (acc_q.size() > 0) got = acc_q.pop_front();
    else got = 48'hFFFF_FFFF_FFFF;
    check(tag, got, exp);
  endtask

  // Accepted frames and out_valid rise time, sampled just before each posedge.
  initial begin
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk_100m);
      #4;
      if (out_valid && out_ready) acc_q.push_back({out_l, out_r});
      if (out_valid && !pv) valid_rise_cyc = cyc;
      pv = out_valid;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One bck period: data changes with bck low, DUT samples on the rise.
  task automatic bck_bit(input logic lr, input logic b, input bit is_rlsb);
    bck = 1'b0; lrck = lr; sdata = b;
    repeat (4) @(negedge clk_100m);
    bck = 1'b1;
    if (is_rlsb) lsb_rise_cyc = cyc;
    if (is_rlsb && rdy_pulse) begin
      // Raise ready exactly in the cycle the new frame is formed.
      repeat (3) @(negedge clk_100m);
      out_ready = 1'b1;
      @(negedge clk_100m);
      out_ready = 1'b0;
      check("hs_valid", 48'(out_valid), 48'd1);
      check("hs_frame", {out_l, out_r}, {frame_l, frame_r});
    end else begin
      repeat (4) @(negedge clk_100m);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_100m);
    rst_n = 1'b0;
    @(negedge clk_100m);
    check("rst_valid", 48'(out_valid), 48'd0);
    check("rst_data", {out_l, out_r}, 48'd0);
    check("rst_flags", {46'd0, overrun, frame_err}, 48'd0);
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int llen, input int rlen, input int rst_at);
    logic [23:0] sh;
    frame_l = l;
    frame_r = r;
    sh = l;
    for (int i = 0; i < llen; i++) begin
      if (i == 0) bck_bit(1'b0, prev_lsb, 1'b0);
      else if (i <= 24) begin
        bck_bit(1'b0, sh[23], 1'b0);
        sh = sh << 1;
      end else bck_bit(1'b0, 1'b0, 1'b0);
    end
    sh = r;
    for (int i = 0; i < rlen; i++) begin
      if (i == 0) bck_bit(1'b1, l[0], 1'b0);
      else if (i <= 24) begin
        bck_bit(1'b1, sh[23], i == 24);
        sh = sh << 1;
      end else bck_bit(1'b1, 1'b0, 1'b0);
      if (i == rst_at) do_reset();
    end
    prev_lsb = r[0];
  endtask

  task automatic pulse_clr();
    @(negedge clk_100m);
    err_clr = 1'b1;
    @(negedge clk_100m);
    err_clr = 1'b0;
    @(negedge clk_100m);
  endtask

  initial begin
    rst_n = 1'b0; bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
    err_clr = 1'b0; out_ready = 1'b1;

    // Reset with bck running and lrck static.
    repeat (3) bck_bit(1'b0, 1'b1, 1'b0);
    check("reset_valid", 48'(out_valid), 48'd0);
    check("reset_data", {out_l, out_r}, 48'd0);
    check("reset_flags", {46'd0, overrun, frame_err}, 48'd0);
    rst_n = 1'b1;
    repeat (6) bck_bit(1'b0, 1'b1, 1'b0);
    check("unlocked_valid", 48'(out_valid), 48'd0);
    check("unlocked_ferr", 48'(frame_err), 48'd0);

    // Start mid-right-slot with junk, then nominal frames.
    repeat (20) bck_bit(1'b1, 1'b1, 1'b0);
    check("midright_none", 48'(acc_q.size()), 48'd0);
    repeat (3) send_frame(24'h123456, 24'hABCDEF, 32, 32, -1);
    check("nom_count", 48'(acc_q.size()), 48'd3);
    for (int i = 0; i < 3; i++) expect_frame("nom_frame", {24'h123456, 24'hABCDEF});
    check("nom_latency", 48'(valid_rise_cyc - lsb_rise_cyc), 48'd4);
    check("nom_flags", {46'd0, overrun, frame_err}, 48'd0);

    // Backpressure over 3 frames, then release on the forming cycle.
    out_ready = 1'b0;
    send_frame(24'h111111, 24'h222222, 32, 32, -1);
    send_frame(24'h333333, 24'h444444, 32, 32, -1);
    send_frame(24'h555555, 24'h666666, 32, 32, -1);
    check("bp_valid", 48'(out_valid), 48'd1);
    check("bp_held", {out_l, out_r}, {24'h111111, 24'h222222});
    check("bp_overrun", 48'(overrun), 48'd1);
    rdy_pulse = 1'b1;
    send_frame(24'h777777, 24'h888888, 32, 32, -1);
    rdy_pulse = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk_100m);
    check("bp_drained", 48'(out_valid), 48'd0);
    check("bp_count", 48'(acc_q.size()), 48'd2);
    expect_frame("bp_first", {24'h111111, 24'h222222});
    expect_frame("bp_new", {24'h777777, 24'h888888});
    pulse_clr();
    check("ovr_clr", 48'(overrun), 48'd0);

    // Short left slot.
    send_frame(24'hAAAAAA, 24'hBBBBBB, 31, 32, -1);
    check("short_ferr", 48'(frame_err), 48'd1);
    check("short_dropped", 48'(acc_q.size()), 48'd0);
    send_frame(24'hCCCCCC, 24'hDDDDDD, 32, 32, -1);
    check("short_next_count", 48'(acc_q.size()), 48'd1);
    expect_frame("short_next", {24'hCCCCCC, 24'hDDDDDD});
    pulse_clr();
    check("ferr_clr", 48'(frame_err), 48'd0);

    // Reset mid-right-slot, then relock on the next lrck fall.
    send_frame(24'h135790, 24'h2468AC, 32, 32, 10);
    check("rst_partial", 48'(acc_q.size()), 48'd0);
    send_frame(24'h7FFFFF, 24'h800001, 32, 32, -1);
    check("relock_count", 48'(acc_q.size()), 48'd1);
    expect_frame("relock_frame", {24'h7FFFFF, 24'h800001});
    check("relock_flags", {46'd0, overrun, frame_err}, 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
